// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  // First fetch address after reset unless overridden at instantiation
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  // Canonical RISC-V NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP = 32'h0000_0013;

  // One buffered fetch result: instruction word plus the PC it came from
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } entry_t;

  // Instructions are word aligned; drop the byte offset of a target address
  function automatic logic [63:0] word_align(input logic [63:0] a);
    return a & ~64'h3;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction memory handshake, decode handoff and redirect.
interface ifetch_if;

  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  // Fetch stage side
  modport master (
    input  stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  // Environment side: memory, decode and branch/exception path
  modport slave (
    output stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/ifetch_queue.sv
// Two-entry FIFO holding fetched instructions with their PCs.
module ifetch_queue
  import ifetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  entry_t     i_data,
  output entry_t     o_head,
  output logic [1:0] o_count,
  output logic       o_full,
  output logic       o_empty
);

  entry_t     r_mem [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Guard against overflow/underflow so the pointers can never desynchronise
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage, pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, single-outstanding memory reads and a decode-side queue.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
)(
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus
);

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_req_pc;

  entry_t      w_head;
  entry_t      w_push_data;
  logic [1:0]  w_count;
  logic [1:0]  w_count_after;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_room_after;

  // A redirect flushes the queue, so it suppresses both push and pop
  assign w_pop  = !w_empty && !bus.stall && !bus.redirect;
  assign w_push = (r_state == ST_WAIT) && bus.imem_rvalid && !bus.redirect;

  assign w_push_data.inst = bus.imem_rdata;
  assign w_push_data.pc   = r_req_pc;

  // Occupancy once this cycle's push/pop land; issue only if a slot stays free
  assign w_count_after = w_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_room_after  = (w_count_after < 2'd2);

  ifetch_queue u_queue (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.imem_req   = (r_state == ST_REQ);
  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = !w_empty;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

  // Fetch FSM and PC: redirect wins over everything, an in-flight read is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else if (bus.redirect) begin
      r_pc <= word_align(bus.redirect_pc);
      unique case (r_state)
        ST_IDLE: r_state <= ST_REQ;
        ST_REQ:  r_state <= bus.imem_gnt ? ST_DROP : ST_REQ;
        ST_WAIT,
        ST_DROP: r_state <= bus.imem_rvalid ? ST_REQ : ST_DROP;
        default: r_state <= ST_IDLE;
      endcase
    end else begin
      unique case (r_state)
        ST_IDLE: if (!w_full) r_state <= ST_REQ;
        ST_REQ: begin
          if (bus.imem_gnt) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + 64'd4;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: if (bus.imem_rvalid) r_state <= w_room_after ? ST_REQ : ST_IDLE;
        ST_DROP: if (bus.imem_rvalid) r_state <= ST_REQ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
